fft_frame_loader: RTL

- Collects a serial stream of real 16-bit audio samples into complete N-point frames.
- Presents each frame in parallel, one sample per slot, to the first FFT butterfly stage, with a valid/ready handshake.
- Ping-pong double buffering lets frame k+1 fill while frame k is held stable downstream.
- Sits between the AXI sample source and the level-1 butterfly array; frame slot k drives the stage input in_k.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_frame_bank.sv | 28 ++
 rtl/fft_frame_loader.sv | 119 +++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared sizes, sample/frame types and the slot-order helper for the FFT
// frame loader. Slot reordering is selected with FFT_LOADER_BITREV_EN.
package fft_pkg;

  localparam int N_POINTS = 32;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 5;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef sample_t [N_POINTS-1:0]   frame_t;

  function automatic logic [ADDR_W-1:0] bitrev(
    input logic [ADDR_W-1:0] n
  );
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = n[ADDR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of sample registers: single write port, full parallel read.
// Cleared by synchronous reset so an idle bank presents all zeros.
module fft_frame_bank #(
  parameter int N  = 32,
  parameter int DW = 16,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [N*DW-1:0] rdata
);

  logic [N-1:0][DW-1:0] mem;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem;

endmodule

// File: rtl/fft_frame_loader.sv
// Serial-to-parallel ping-pong frame loader feeding the first FFT stage.
// Define FFT_LOADER_BITREV_EN to store samples in bit-reversed slot order.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int N_POINTS = fft_pkg::N_POINTS,
  parameter int DATA_W   = fft_pkg::DATA_W,
  parameter int ADDR_W   = fft_pkg::ADDR_W
) (
  input  logic                       clk_100MHz,
  input  logic                       rstn,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_last,
  output logic [N_POINTS*DATA_W-1:0] frame_data,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic                       frame_err
);

  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] slot;
  logic              fill_sel;
  logic              present_sel;
  logic              fill_full;

  logic acc;
  logic at_end;
  logic done;
  logic early;
  logic consume;
  logic free;
  logic swap;
  logic we0;
  logic we1;

  logic [N_POINTS*DATA_W-1:0] rd0;
  logic [N_POINTS*DATA_W-1:0] rd1;

  assign s_ready = rstn & ~fill_full;

  assign acc     = s_valid & s_ready;
  assign at_end  = wr_cnt == ADDR_W'(N_POINTS - 1);
  assign done    = acc & at_end;
  assign early   = acc & s_last & ~at_end;
  assign consume = frame_valid & frame_ready;
  assign free    = ~frame_valid | frame_ready;

  // A held full bank swaps in as soon as the present one is taken.
  assign swap = (done & free) | (fill_full & consume);

`ifdef FFT_LOADER_BITREV_EN
  assign slot = bitrev(wr_cnt);
`else
  assign slot = wr_cnt;
`endif

  assign we0 = acc & ~fill_sel;
  assign we1 = acc & fill_sel;

  fft_frame_bank #(
    .N  (N_POINTS),
    .DW (DATA_W),
    .AW (ADDR_W)
  ) u_bank0 (
    .clk   (clk_100MHz),
    .rstn  (rstn),
    .we    (we0),
    .addr  (slot),
    .wdata (s_data),
    .rdata (rd0)
  );

  fft_frame_bank #(
    .N  (N_POINTS),
    .DW (DATA_W),
    .AW (ADDR_W)
  ) u_bank1 (
    .clk   (clk_100MHz),
    .rstn  (rstn),
    .we    (we1),
    .addr  (slot),
    .wdata (s_data),
    .rdata (rd1)
  );

  always_ff @(posedge clk_100MHz) begin
    if (!rstn) begin
      wr_cnt      <= '0;
      fill_sel    <= 1'b0;
      present_sel <= 1'b0;
      fill_full   <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= early | (done & ~s_last);
      if (acc) begin
        wr_cnt <= (done | early) ? '0 : wr_cnt + 1'b1;
      end
      if (swap) begin
        present_sel <= fill_sel;
        fill_sel    <= ~fill_sel;
        frame_valid <= 1'b1;
        fill_full   <= 1'b0;
      end else begin
        if (done) begin
          fill_full <= 1'b1;
        end
        if (consume) begin
          frame_valid <= 1'b0;
        end
      end
    end
  end

  assign frame_data = present_sel ? rd1 : rd0;

endmodule
